// File: rtl/rom_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single non-pipelined ROM read port.
// One transaction in flight at a time: IDLE -> WAIT (LATENCY+1 cycles) -> RESP (1 cycle).
module rom_port_arbiter #(
    parameter int unsigned MEM_ADDR  = 6,
    parameter int unsigned MEM_EXTRA = 4,
    parameter int unsigned LATENCY   = 1,
    localparam int unsigned AW = MEM_ADDR + 1,
    localparam int unsigned DW = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [MEM_EXTRA-1:0] extra0,
    input  logic [MEM_EXTRA-1:0] extra1,
    input  logic [AW-1:0]        lo0,
    input  logic [AW-1:0]        lo1,
    input  logic [AW-1:0]        hi0,
    input  logic [AW-1:0]        hi1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DW-1:0]        rdata,
    output logic                 rerror,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [AW-1:0]        mem_lower_bound,
    output logic [AW-1:0]        mem_upper_bound,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error,
    output logic                 busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    localparam logic [1:0] LatCnt = 2'(LATENCY);

    state_t     state;
    logic [1:0] cnt;
    logic       last_grant;
    logic       pick1;

    // Winner selection: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        pick1 = req1 & (~req0 | ~last_grant);
    end

    // Arbitration FSM with registered grant/response/ROM-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= StIdle;
            cnt             <= 2'd0;
            last_grant      <= 1'b1;
            gnt0            <= 1'b0;
            gnt1            <= 1'b0;
            rvalid0         <= 1'b0;
            rvalid1         <= 1'b0;
            busy            <= 1'b0;
            rdata           <= '0;
            rerror          <= 1'b0;
            mem_addr        <= '0;
            mem_extra       <= '0;
            mem_lower_bound <= '0;
            mem_upper_bound <= '1;
        end else begin
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        if (pick1) begin
                            mem_addr        <= addr1;
                            mem_extra       <= extra1;
                            mem_lower_bound <= lo1;
                            mem_upper_bound <= hi1;
                            gnt1            <= 1'b1;
                        end else begin
                            mem_addr        <= addr0;
                            mem_extra       <= extra0;
                            mem_lower_bound <= lo0;
                            mem_upper_bound <= hi0;
                            gnt0            <= 1'b1;
                        end
                        busy       <= 1'b1;
                        cnt        <= 2'd0;
                        last_grant <= pick1;
                        state      <= StWait;
                    end
                end
                StWait: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    cnt  <= cnt + 2'd1;
                    if (cnt == LatCnt) begin
                        rdata   <= mem_data;
                        rerror  <= mem_error;
                        rvalid0 <= ~last_grant;
                        rvalid1 <= last_grant;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    // Always return through IDLE so no grant is issued on this edge.
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: three instances (LATENCY 1, 0, 3) share a
// behavioural ROM model; stimulus pushes expected grants/responses, monitors pop and compare.
module tb_rom_port_arbiter;

    localparam int AW = 7;
    localparam int EW = 4;
    localparam int DW = 128;
    localparam int N  = 3;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          rst     [N];
    logic          req0    [N];
    logic          req1    [N];
    logic [AW-1:0] addr0   [N];
    logic [AW-1:0] addr1   [N];
    logic [EW-1:0] extra0  [N];
    logic [EW-1:0] extra1  [N];
    logic [AW-1:0] lo0     [N];
    logic [AW-1:0] lo1     [N];
    logic [AW-1:0] hi0     [N];
    logic [AW-1:0] hi1     [N];
    logic          gnt0    [N];
    logic          gnt1    [N];
    logic          rvalid0 [N];
    logic          rvalid1 [N];
    logic [DW-1:0] rdata   [N];
    logic          rerror  [N];
    logic [AW-1:0] m_addr  [N];
    logic [EW-1:0] m_extra [N];
    logic [AW-1:0] m_lb    [N];
    logic [AW-1:0] m_ub    [N];
    logic [DW-1:0] m_data  [N];
    logic          m_err   [N];
    logic          busy    [N];

    int   gnt_q [N][$];
    rsp_t rsp_q [N][$];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a, input logic [EW-1:0] e);
        logic [7:0] b;
        b = {1'b0, a} ^ 8'h5A;
        if (a == 7'h05 && e == 4'h3) return 128'h123456;
        return {16{b}} ^ {124'd0, e};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        rom_port_arbiter #(
            .MEM_ADDR (6),
            .MEM_EXTRA(4),
            .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk            (clk),
            .reset          (rst[g]),
            .req0           (req0[g]),
            .req1           (req1[g]),
            .addr0          (addr0[g]),
            .addr1          (addr1[g]),
            .extra0         (extra0[g]),
            .extra1         (extra1[g]),
            .lo0            (lo0[g]),
            .lo1            (lo1[g]),
            .hi0            (hi0[g]),
            .hi1            (hi1[g]),
            .gnt0           (gnt0[g]),
            .gnt1           (gnt1[g]),
            .rvalid0        (rvalid0[g]),
            .rvalid1        (rvalid1[g]),
            .rdata          (rdata[g]),
            .rerror         (rerror[g]),
            .mem_addr       (m_addr[g]),
            .mem_extra      (m_extra[g]),
            .mem_lower_bound(m_lb[g]),
            .mem_upper_bound(m_ub[g]),
            .mem_data       (m_data[g]),
            .mem_error      (m_err[g]),
            .busy           (busy[g])
        );

        // Behavioural ROM: data keyed on address/extra, error on out-of-window address.
        assign m_data[g] = rom_word(m_addr[g], m_extra[g]);
        assign m_err[g]  = (m_addr[g] < m_lb[g]) || (m_addr[g] > m_ub[g]);

        // Monitor: pops expectations whenever a grant or response appears.
        initial begin
            int   gcyc;
            int   rcyc;
            int   p;
            int   eg;
            rsp_t r;
            gcyc = -100;
            rcyc = -100;
            forever begin
                @(negedge clk);
                if (!rst[g]) begin
                    if (gnt0[g] || gnt1[g]) begin
                        chk("gnt_exclusive", {127'd0, gnt0[g] & gnt1[g]}, '0);
                        p = gnt1[g] ? 1 : 0;
                        if (gnt_q[g].size() == 0) begin
                            chk("gnt_unexpected", DW'(p), DW'(-1));
                        end else begin
                            eg = gnt_q[g].pop_front();
                            chk("gnt_port", DW'(p), DW'(eg));
                        end
                        gcyc = cyc;
                    end
                    if (rvalid0[g] || rvalid1[g]) begin
                        chk("rvalid_exclusive", {127'd0, rvalid0[g] & rvalid1[g]}, '0);
                        p = rvalid1[g] ? 1 : 0;
                        if (rsp_q[g].size() == 0) begin
                            chk("rsp_unexpected", DW'(p), DW'(-1));
                        end else begin
                            r = rsp_q[g].pop_front();
                            chk("rsp_port", DW'(p), DW'(r.port));
                            chk("rsp_data", rdata[g], r.data);
                            chk("rsp_error", {127'd0, rerror[g]}, {127'd0, r.err});
                            chk("rsp_latency", DW'(cyc - gcyc), DW'(lat_of(g) + 1));
                            chk("busy_in_resp", {127'd0, busy[g]}, 128'd1);
                        end
                        rcyc = cyc;
                    end else if (cyc == rcyc + 1) begin
                        chk("busy_after_resp", {127'd0, busy[g]}, '0);
                    end
                end
            end
        end
    end

    task automatic issue(input int i, input int port, input logic [AW-1:0] a,
                         input logic [EW-1:0] e, input logic [AW-1:0] lo,
                         input logic [AW-1:0] hi);
        rsp_t r;
        r.port = port;
        r.data = rom_word(a, e);
        r.err  = (a < lo) || (a > hi);
        gnt_q[i].push_back(port);
        rsp_q[i].push_back(r);
        if (port == 0) begin
            addr0[i] = a; extra0[i] = e; lo0[i] = lo; hi0[i] = hi; req0[i] = 1'b1;
        end else begin
            addr1[i] = a; extra1[i] = e; lo1[i] = lo; hi1[i] = hi; req1[i] = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int i, output int gcyc, output int waited);
        gcyc   = -1;
        waited = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (gnt0[i] || gnt1[i]) begin
                gcyc   = cyc;
                waited = n;
                break;
            end
        end
        if (gcyc < 0) timeout("wait_gnt");
    endtask

    task automatic wait_idle(input int i);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy[i] && rsp_q[i].size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("wait_idle");
        @(negedge clk);
    endtask

    task automatic single(input int i, input int port, input logic [AW-1:0] a,
                          input logic [EW-1:0] e, input logic [AW-1:0] lo,
                          input logic [AW-1:0] hi);
        int gc;
        int w;
        issue(i, port, a, e, lo, hi);
        wait_gnt(i, gc, w);
        chk("gnt_delay", DW'(w), DW'(1));
        if (port == 0) req0[i] = 1'b0;
        else req1[i] = 1'b0;
        wait_idle(i);
    endtask

    task automatic chk_reset(input int i);
        chk("rst_gnt0", {127'd0, gnt0[i]}, '0);
        chk("rst_gnt1", {127'd0, gnt1[i]}, '0);
        chk("rst_rvalid0", {127'd0, rvalid0[i]}, '0);
        chk("rst_rvalid1", {127'd0, rvalid1[i]}, '0);
        chk("rst_busy", {127'd0, busy[i]}, '0);
        chk("rst_rdata", rdata[i], '0);
        chk("rst_rerror", {127'd0, rerror[i]}, '0);
        chk("rst_mem_addr", DW'(m_addr[i]), '0);
        chk("rst_mem_extra", DW'(m_extra[i]), '0);
        chk("rst_lower", DW'(m_lb[i]), '0);
        chk("rst_upper", DW'(m_ub[i]), DW'(7'h7F));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc;
        int pc;
        int w;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0;
            addr0[i] = '0; addr1[i] = '0; extra0[i] = '0; extra1[i] = '0;
            lo0[i] = '0; lo1[i] = '0; hi0[i] = '0; hi1[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) chk_reset(i);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        @(negedge clk);

        // Tie with both held: alternating grants, one idle cycle between transactions.
        for (int k = 0; k < 4; k++) begin
            issue(0, 0, 7'h10, 4'h1, 7'h00, 7'h7F);
            issue(0, 1, 7'h22, 4'h2, 7'h00, 7'h7F);
        end
        pc = -1;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(0, gc, w);
            if (k > 0) chk("gnt_period", DW'(gc - pc), DW'(lat_of(0) + 3));
            pc = gc;
            if (k == 6) req0[0] = 1'b0;
            if (k == 7) req1[0] = 1'b0;
        end
        wait_idle(0);

        // Single request, ROM returns 0x123456; mem_* hold afterwards.
        single(0, 0, 7'h05, 4'h3, 7'h00, 7'h7F);
        chk("mem_addr_hold", DW'(m_addr[0]), DW'(7'h05));
        chk("mem_extra_hold", DW'(m_extra[0]), DW'(4'h3));

        // Out-of-window read on requester 1, then an in-window read on requester 0.
        issue(0, 1, 7'h30, 4'h7, 7'h00, 7'h1F);
        wait_gnt(0, gc, w);
        req1[0] = 1'b0;
        chk("bound_upper", DW'(m_ub[0]), DW'(7'h1F));
        chk("bound_lower", DW'(m_lb[0]), '0);
        wait_idle(0);
        single(0, 0, 7'h08, 4'h1, 7'h00, 7'h1F);
        chk("rdata_hold", rdata[0], rom_word(7'h08, 4'h1));

        // Request raised mid-transaction waits for the edge after RESP.
        issue(0, 0, 7'h03, 4'h2, 7'h00, 7'h7F);
        wait_gnt(0, pc, w);
        req0[0] = 1'b0;
        @(negedge clk);
        issue(0, 1, 7'h11, 4'h5, 7'h00, 7'h7F);
        wait_gnt(0, gc, w);
        req1[0] = 1'b0;
        chk("late_gnt_gap", DW'(gc - pc), DW'(lat_of(0) + 3));
        wait_idle(0);

        // Latency sweep.
        single(1, 0, 7'h05, 4'h3, 7'h00, 7'h7F);
        single(1, 1, 7'h2C, 4'h9, 7'h10, 7'h3F);
        single(2, 1, 7'h05, 4'h3, 7'h00, 7'h7F);
        single(2, 0, 7'h7E, 4'hE, 7'h00, 7'h7F);

        // Reset one cycle into WAIT: transaction abandoned, no response expected.
        gnt_q[2].push_back(1);
        addr1[2] = 7'h12; extra1[2] = 4'h4; lo1[2] = 7'h00; hi1[2] = 7'h7F; req1[2] = 1'b1;
        wait_gnt(2, gc, w);
        req1[2] = 1'b0;
        @(posedge clk);
        #2;
        rst[2] = 1'b1;
        #1;
        chk_reset(2);
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_rvalid_after_reset", DW'(rsp_q[2].size()), '0);

        // After reset requester 0 wins the first tie again.
        issue(2, 0, 7'h01, 4'h0, 7'h00, 7'h7F);
        issue(2, 1, 7'h02, 4'h1, 7'h00, 7'h7F);
        wait_gnt(2, gc, w);
        chk("first_tie_is_0", {127'd0, gnt0[2]}, 128'd1);
        req0[2] = 1'b0;
        wait_gnt(2, gc, w);
        req1[2] = 1'b0;
        wait_idle(2);

        for (int i = 0; i < N; i++) begin
            chk("gnt_q_drained", DW'(gnt_q[i].size()), '0);
            chk("rsp_q_drained", DW'(rsp_q[i].size()), '0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
